fadd_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the single-issue combinational `fadd`.
- Generic exponent/mantissa widths. Adds an op-select for subtraction, round-to-nearest-even, special-value handling and exception flags.
- Fixed 3-stage pipeline with valid/ready handshake on both sides, so it can sit between the FPU issue queue and the result writeback arbiter.

---
 rtl/fadd_pipe.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - pipelined floating-point adder/subtractor with valid/ready handshake
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   unf,
  output logic                   nv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  // significand with hidden bit plus guard, round and sticky positions
  localparam int SW = MAN_W + 4;
  // signed exponent with headroom for carry-out and left normalisation
  localparam int EW = EXP_W + 2;

  localparam logic [W-1:0]          QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0]  EXP_TOP = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0]  EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0]  EXP_NIL = '0;

  // Whole pipeline moves together; nothing moves while a result waits for the consumer.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage 1 register: accepted operands
  // ---------------------------------------------------------------------------
  logic         s1_valid;
  logic [W-1:0] s1_x1;
  logic [W-1:0] s1_x2;
  logic         s1_sub;

  // Capture operands on an accepting edge, or a bubble when in_valid is low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_sub   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_x1    <= x1;
      s1_x2    <= x2;
      s1_sub   <= sub;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 logic: unpack, classify, swap, align
  // ---------------------------------------------------------------------------
  logic             a_sgn, b_sgn;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frc, b_frc;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [MAN_W:0]   a_sig, b_sig, big_sig, sml_sig;
  logic [EXP_W-1:0] sml_exp, exp_diff;
  logic [SW-1:0]    sml_ext, sml_aln;
  logic             a_ge_b, lost;
  logic             c1_special, c1_nv, c1_sgn, c1_eff_sub;
  logic [W-1:0]     c1_spec_y;
  logic [EXP_W-1:0] c1_exp;
  logic [SW-1:0]    c1_big;

  // Decode operands, pick special results, order by magnitude and align the smaller one
  always_comb begin
    a_sgn  = s1_x1[W-1];
    a_exp  = s1_x1[W-2:MAN_W];
    a_frc  = s1_x1[MAN_W-1:0];
    b_sgn  = s1_x2[W-1] ^ s1_sub;
    b_exp  = s1_x2[W-2:MAN_W];
    b_frc  = s1_x2[MAN_W-1:0];

    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == '1) && (a_frc == '0);
    b_inf  = (b_exp == '1) && (b_frc == '0);
    a_nan  = (a_exp == '1) && (a_frc != '0);
    b_nan  = (b_exp == '1) && (b_frc != '0);
    a_snan = a_nan && !a_frc[MAN_W-1];
    b_snan = b_nan && !b_frc[MAN_W-1];

    // denormals carry no significand: they behave exactly like signed zero
    a_sig  = a_zero ? '0 : {1'b1, a_frc};
    b_sig  = b_zero ? '0 : {1'b1, b_frc};

    c1_special = 1'b0;
    c1_nv      = 1'b0;
    c1_spec_y  = '0;
    if (a_nan || b_nan) begin
      c1_special = 1'b1;
      c1_spec_y  = QNAN;
      c1_nv      = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_sgn != b_sgn)) begin
      c1_special = 1'b1;
      c1_spec_y  = QNAN;
      c1_nv      = 1'b1;
    end else if (a_inf) begin
      c1_special = 1'b1;
      c1_spec_y  = {a_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_special = 1'b1;
      c1_spec_y  = {b_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      // only (-0)+(-0) keeps the negative sign
      c1_special = 1'b1;
      c1_spec_y  = {a_sgn & b_sgn, {(W-1){1'b0}}};
    end

    a_ge_b     = {a_exp, a_sig} >= {b_exp, b_sig};
    c1_sgn     = a_ge_b ? a_sgn : b_sgn;
    c1_exp     = a_ge_b ? a_exp : b_exp;
    big_sig    = a_ge_b ? a_sig : b_sig;
    sml_sig    = a_ge_b ? b_sig : a_sig;
    sml_exp    = a_ge_b ? b_exp : a_exp;
    c1_eff_sub = a_sgn ^ b_sgn;
    c1_big     = {big_sig, 3'b000};

    exp_diff = c1_exp - sml_exp;
    sml_ext  = {sml_sig, 3'b000};
    lost     = 1'b0;
    if (int'(exp_diff) >= SW) begin
      sml_aln = {{(SW-1){1'b0}}, |sml_sig};
    end else begin
      sml_aln = sml_ext >> exp_diff;
      for (int i = 0; i < SW; i++) begin
        if (i < int'(exp_diff)) lost = lost | sml_ext[i];
      end
      sml_aln[0] = sml_aln[0] | lost;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 register: ordered, aligned significands
  // ---------------------------------------------------------------------------
  logic             s2_valid, s2_special, s2_nv, s2_sgn, s2_eff_sub;
  logic [W-1:0]     s2_spec_y;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_big, s2_sml;

  // Hand aligned operands to the adder stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid   <= 1'b0;
      s2_special <= 1'b0;
      s2_nv      <= 1'b0;
      s2_sgn     <= 1'b0;
      s2_eff_sub <= 1'b0;
      s2_spec_y  <= '0;
      s2_exp     <= '0;
      s2_big     <= '0;
      s2_sml     <= '0;
    end else if (advance) begin
      s2_valid   <= s1_valid;
      s2_special <= c1_special;
      s2_nv      <= c1_nv;
      s2_sgn     <= c1_sgn;
      s2_eff_sub <= c1_eff_sub;
      s2_spec_y  <= c1_spec_y;
      s2_exp     <= c1_exp;
      s2_big     <= c1_big;
      s2_sml     <= sml_aln;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 logic: add/subtract, leading-zero count, normalise
  // ---------------------------------------------------------------------------
  logic [SW:0]          sum;
  logic [EW-1:0]        lz;
  logic                 found;
  logic signed [EW-1:0] exp_s;
  logic signed [EW-1:0] c2_exp;
  logic [SW-1:0]        c2_sig;
  logic                 c2_zero;

  // Magnitude ordering guarantees the difference is never negative
  always_comb begin
    sum     = s2_eff_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                         : ({1'b0, s2_big} + {1'b0, s2_sml});
    exp_s   = $signed({2'b00, s2_exp});
    lz      = '0;
    found   = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + 1'b1;
      end
    end

    c2_zero = 1'b0;
    c2_sig  = '0;
    c2_exp  = '0;
    if (sum == '0) begin
      c2_zero = 1'b1;
    end else if (sum[SW]) begin
      // carry-out: shift right one, folding the dropped bit into sticky
      c2_sig = sum[SW:1] | {{(SW-1){1'b0}}, sum[0]};
      c2_exp = exp_s + EXP_ONE;
    end else begin
      c2_sig = sum[SW-1:0] << lz;
      c2_exp = exp_s - $signed(lz);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 register: normalised significand awaiting rounding
  // ---------------------------------------------------------------------------
  logic                 s3_valid, s3_special, s3_nv, s3_sgn, s3_zero;
  logic [W-1:0]         s3_spec_y;
  logic signed [EW-1:0] s3_exp;
  logic [SW-1:0]        s3_sig;

  // Hand normalised result to the rounding stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid   <= 1'b0;
      s3_special <= 1'b0;
      s3_nv      <= 1'b0;
      s3_sgn     <= 1'b0;
      s3_zero    <= 1'b0;
      s3_spec_y  <= '0;
      s3_exp     <= '0;
      s3_sig     <= '0;
    end else if (advance) begin
      s3_valid   <= s2_valid;
      s3_special <= s2_special;
      s3_nv      <= s2_nv;
      s3_sgn     <= s2_sgn;
      s3_zero    <= c2_zero;
      s3_spec_y  <= s2_spec_y;
      s3_exp     <= c2_exp;
      s3_sig     <= c2_sig;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 logic: round to nearest even, range check, pack
  // ---------------------------------------------------------------------------
  logic [MAN_W:0]       keep;
  logic                 g_bit, st_bit, inc;
  logic [MAN_W+1:0]     rnd;
  logic signed [EW-1:0] rexp;
  logic [MAN_W-1:0]     rfrc;
  logic [W-1:0]         c3_y;
  logic                 c3_ovf, c3_unf;

  // Round, then decide between special, zero, overflow, underflow or normal packing
  always_comb begin
    keep   = s3_sig[SW-1:3];
    g_bit  = s3_sig[2];
    st_bit = |s3_sig[1:0];
    inc    = g_bit && (st_bit || keep[0]);
    rnd    = {1'b0, keep} + {{(MAN_W+1){1'b0}}, inc};
    if (rnd[MAN_W+1]) begin
      rexp = s3_exp + EXP_ONE;
      rfrc = rnd[MAN_W:1];
    end else begin
      rexp = s3_exp;
      rfrc = rnd[MAN_W-1:0];
    end

    c3_ovf = 1'b0;
    c3_unf = 1'b0;
    c3_y   = {s3_sgn, rexp[EXP_W-1:0], rfrc};
    if (s3_special) begin
      c3_y = s3_spec_y;
    end else if (s3_zero) begin
      c3_y = '0;
    end else if (rexp >= EXP_TOP) begin
      c3_y   = {s3_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c3_ovf = 1'b1;
    end else if (rexp <= EXP_NIL) begin
      c3_y   = {s3_sgn, {(W-1){1'b0}}};
      c3_unf = 1'b1;
    end
  end

  // Output register; flags and data forced to zero alongside a bubble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nv        <= 1'b0;
    end else if (advance) begin
      out_valid <= s3_valid;
      y         <= s3_valid ? c3_y : '0;
      ovf       <= s3_valid && c3_ovf;
      unf       <= s3_valid && c3_unf;
      nv        <= s3_valid && s3_nv && s3_special;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb/tb_fadd_pipe.sv - directed vector bench for fadd_pipe
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        ovf, unf, nv;

  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [15:0] h_x1 = '0;
  logic [15:0] h_x2 = '0;
  logic        h_out_valid;
  logic [15:0] h_y;
  logic        h_ovf, h_unf, h_nv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        nv;
    string       name;
  } vec_t;

  vec_t tv[18];

  fadd_pipe dut32 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .unf(unf), .nv(nv)
  );

  fadd_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rstn(rstn),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .x1(h_x1), .x2(h_x2), .sub(1'b0),
    .out_valid(h_out_valid), .out_ready(1'b1),
    .y(h_y), .ovf(h_ovf), .unf(h_unf), .nv(h_nv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input vec_t v);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    x1 = v.a;
    x2 = v.b;
    sub = v.s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({v.name, "_lat"}, n, 3);
    check({v.name, "_y"}, y, v.y);
    check({v.name, "_ovf"}, ovf, v.ovf);
    check({v.name, "_unf"}, unf, v.unf);
    check({v.name, "_nv"}, nv, v.nv);
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ey, input logic eovf);
    int n;
    @(negedge clk);
    h_in_valid = 1'b1;
    h_x1 = a;
    h_x2 = b;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    n = 0;
    while (!h_out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_lat"}, n, 3);
    check({name, "_y"}, h_y, ey);
    check({name, "_ovf"}, h_ovf, eovf);
  endtask

  initial begin
    int ops[5];
    int idx;
    int got;
    logic acc;
    logic prev_stall;
    logic [31:0] held;
    logic any_valid;

    tv[0]  = '{32'h40400000, 32'hC0400000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, "cancel"};
    tv[1]  = '{32'h4048F5C3, 32'h40000000, 1'b0, 32'h40A47AE2, 1'b0, 1'b0, 1'b0, "tie_even"};
    tv[2]  = '{32'h3F800000, 32'h3F8CCCCD, 1'b0, 32'h40066666, 1'b0, 1'b0, 1'b0, "sum_1p1"};
    tv[3]  = '{32'h40200000, 32'hC0000000, 1'b1, 32'h40900000, 1'b0, 1'b0, 1'b0, "sub_neg"};
    tv[4]  = '{32'h40400000, 32'hC37F0000, 1'b0, 32'hC37C0000, 1'b0, 1'b0, 1'b0, "mixed_sign"};
    tv[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, "overflow"};
    tv[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "inf_minus_inf"};
    tv[7]  = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, "denorm_flush"};
    tv[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, "neg_zero"};
    tv[9]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, "x_minus_x"};
    tv[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0, "qnan_in"};
    tv[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "snan_in"};
    tv[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b0, "inf_finite"};
    tv[13] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, "underflow"};
    tv[14] = '{32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, "sticky_borrow"};
    tv[15] = '{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 1'b0, "cancel_norm"};
    tv[16] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "inf_sub_inf"};
    tv[17] = '{32'h00000000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0, "zero_plus_neg"};

    // reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 32'h0);
    check("rst_flags", {ovf, unf, nv}, 3'b000);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    // table of single operations
    for (int i = 0; i < 18; i++) run32(tv[i]);

    // half precision instance
    run16("h_one_plus_one", 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    run16("h_overflow", 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);

    // five back-to-back ops with the consumer stalled in cycles 4..6
    ops = '{1, 2, 3, 4, 15};
    idx = 0;
    got = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (idx < 5);
      if (idx < 5) begin
        x1  = tv[ops[idx]].a;
        x2  = tv[ops[idx]].b;
        sub = tv[ops[idx]].s;
      end
      #1;
      if (prev_stall) check("stall_y_hold", y, held);
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 1'b0);
        held = y;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (got < 5) check($sformatf("stream_%0d", got), y, tv[ops[got]].y);
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, 5);

    // reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x1  = tv[k].a;
      x2  = tv[k].b;
      sub = tv[k].s;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check("async_clear_valid", out_valid, 1'b0);
    check("async_clear_y", y, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    any_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      any_valid = any_valid | out_valid;
    end
    check("no_stale_after_reset", any_valid, 1'b0);
    run32(tv[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
